// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential 64x64 shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned MUL_WIDTH = 64;
    localparam int unsigned MUL_ITERS = 64;

endpackage

// File: rtl/adder_64.sv
// 64-bit ripple-carry adder with carry in/out; purely combinational.
module adder_64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        carryin,
    output logic [63:0] result,
    output logic        carryout
);

    always_comb begin : ripple
        logic c;
        c        = carryin;
        result   = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            result[i] = a[i] ^ b[i] ^ c;
            c         = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carryout = c;
    end

endmodule

// File: rtl/mult_seq_64.sv
// Radix-2 shift-add unsigned multiplier: one multiplier bit per cycle through adder_64.
module mult_seq_64
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH,
    parameter int unsigned CNT_W = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITERS - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   add_res;
    logic               add_cout;
    logic [WIDTH:0]     sum65;

    assign addend = lo_q[0] ? mcand_q : '0;

    adder_64 u_adder (
        .a        (hi_q),
        .b        (addend),
        .carryin  (1'b0),
        .result   (add_res),
        .carryout (add_cout)
    );

    // Carry-out is the top bit of the partial sum; it shifts into hi[63].
    assign sum65 = {add_cout, add_res};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    mcand_d = a;
                    hi_d    = '0;
                    lo_d    = b;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                hi_d = sum65[WIDTH:1];
                lo_d = {sum65[0], lo_q[WIDTH-1:1]};
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) begin
                    mcand_d = a;
                    hi_d    = '0;
                    lo_d    = b;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign product = {hi_q, lo_q};

endmodule

// File: doc/mult_seq_64.md
Name: mult_seq_64

Overview:
- Iterative radix-2 shift-add unsigned multiplier, 64x64 -> 128-bit product, one multiplier bit per cycle.
- Sits directly upstream of the 64-bit ripple adder: this block owns the operand/accumulator registers and sequencing, and drives adder_64's A, B and carryin every cycle.
- Consumes adder_64's result and carryout.
- Serves as the multi-cycle MUL path next to the ALU.

Parameters:
- WIDTH, 64, operand width; only 64 is supported because the adder is fixed at 64 bits.
- CNT_W, 7, iteration counter width; must hold the value WIDTH-1 = 63.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset; the block is in reset when reset==0, sampled on the rising edge of clk
- start  input  1  request; sampled only when ready==1
- a  input  64  multiplicand; latched on an accepted start
- b  input  64  multiplier; latched on an accepted start
- ready  output  1  high in IDLE and DONE; a start is accepted in these states
- busy  output  1  high in RUN
- done  output  1  single-cycle pulse; product is valid from this cycle on
- product  output  128  {hi, lo}; held stable from done until the next accepted start

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; mcand, hi, lo and cnt all cleared.
  - Outputs: ready=1, busy=0, done=0, product=0.
  - Reset applies in every state, including mid-RUN: the operation is aborted and no done is produced.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> mcand<=a, hi<=0, lo<=b, cnt<=0, go to RUN. start=0 -> stay.
  - RUN: perform one iteration per edge. cnt==63 on an edge -> that iteration completes and state goes to DONE; otherwise cnt<=cnt+1. start is ignored.
  - DONE: done=1 for exactly this cycle. start=1 -> same load as in IDLE, go to RUN (back-to-back issue). start=0 -> go to IDLE with product held.
- Iteration datapath (combinational into adder_64):
  - adder_64 inputs: A=hi; B = lo[0] ? mcand : 64'b0; carryin=0.
  - sum65 = {carryout, result}.
  - Register update: hi <= sum65[64:1]; lo <= {sum65[0], lo[63:1]}.
  - carryout must equal the carry out of bit 63. It must never be dropped; 2^64-1 squared depends on it.
- Latency:
  - start accepted at edge N.
  - Iterations run on edges N+1..N+64.
  - done=1 in the cycle after edge N+64.
  - Start-to-done is 65 cycles; throughput is one product per 65 cycles when issued back-to-back.
- product = {hi, lo} at all times. It is only architecturally meaningful when done=1 or while ready=1 after a completed run.
- Boundary conditions:
  - Operand 0: still runs all 64 iterations (no early exit); result is 0.
  - a and b are sampled only on acceptance; changes to a and b during RUN have no effect.
  - Simultaneous reset==0 and start=1: reset wins.

Decomposition:
- Shared package mul_pkg:
  - State enum typedef (IDLE, RUN, DONE).
  - Constants MUL_WIDTH=64 and MUL_ITERS=64.
- One sub-module: adder_64, instantiated once and fed from the hi/mcand registers.
- No other hierarchy; the FSM and registers stay in mult_seq_64.

Test Plan:
- Basic product: reset low 2 cycles, then a=3, b=5, start 1 cycle.
  - Required: done exactly 65 cycles after the accepting edge.
  - Required: product=128'h0...0F; busy high for 64 cycles.
- Maximum operands: a=b=64'hFFFF_FFFF_FFFF_FFFF.
  - Required: product=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
  - This exercises the carryout path.
- Carry into the upper half: a=64'h8000_0000_0000_0000, b=2.
  - Required: product=128'h0000_0000_0000_0001_0000_0000_0000_0000.
- Zero and ignored start: a=0, b=64'hDEAD_BEEF.
  - Required: product=0 after 65 cycles.
  - Pulse start with a=7, b=7 in cycle 10 of RUN. Required: it is ignored and the result is still 0.
- Reset mid-run: start with a=9, b=9, then drive reset=0 at iteration 30.
  - Required at the next edge: state IDLE, product=0, busy=0, and no done pulse.
  - Then a fresh start with a=9, b=9. Required: 81.
- Back-to-back: assert start again in the DONE cycle with a=6, b=7.
  - Required: the first product stays valid during done.
  - Required: the second done arrives 65 cycles later with product=42.
